// File: rtl/kb_pkg.sv
// Shared PS/2 keyboard decoder definitions: scancode constants, FSM state type,
// action indices and the default two-player keymap.
package kb_pkg;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_E1 = 8'hE1;
    localparam logic [7:0] SC_F0 = 8'hF0;

    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_BAT_FL = 8'hFC;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    localparam int ACT_UP    = 0;
    localparam int ACT_DOWN  = 1;
    localparam int ACT_LEFT  = 2;
    localparam int ACT_RIGHT = 3;
    localparam int ACT_SHOOT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } kb_state_t;

    // Entry 0 in the LSBs; each entry is {extended, scancode}.
    localparam logic [89:0] KB_DEFAULT_KEYMAP = {
        1'b0, 8'h4C, 1'b1, 8'h74, 1'b1, 8'h6B, 1'b1, 8'h72, 1'b1, 8'h75,
        1'b0, 8'h3B, 1'b0, 8'h23, 1'b0, 8'h1C, 1'b0, 8'h1B, 1'b0, 8'h1D
    };

    // Keyboard status/response bytes that never carry key information.
    function automatic logic kb_is_ignored(input logic [7:0] c);
        return (c == SC_ERR0) || (c == SC_BAT_OK) || (c == SC_ECHO) ||
               (c == SC_ACK) || (c == SC_BAT_FL) || (c == SC_RESEND) ||
               (c == SC_ERR1);
    endfunction

endpackage

// File: rtl/kb_ctrl_decoder_if.sv
// Received-byte stream from the PS/2 receiver into the keyboard decoder.
interface kb_ctrl_decoder_if;

    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;

    modport master (output code, output code_valid, output frame_err);
    modport slave  (input  code, input  code_valid, input  frame_err);

endinterface

// File: rtl/kb_ctrl_decoder_keymap_match.sv
// Combinational comparator: flags every keymap entry equal to a 9-bit
// {extended, scancode} key.
module kb_keymap_match #(
    parameter int               NUM_KEYS = 10,
    parameter logic [NUM_KEYS*9-1:0] KEYMAP = '0
) (
    input  logic [8:0]          key,
    output logic [NUM_KEYS-1:0] match
);

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            match[i] = (KEYMAP[9*i +: 9] == key);
        end
    end

endmodule

// File: rtl/kb_ctrl_decoder.sv
// PS/2 set-2 scancode decoder producing held key state per player action.
// Optional one-cycle press strobes are built when KB_PRESS_PULSE_EN is defined.
module kb_ctrl_decoder
    import kb_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_ACTIONS = 5,
    parameter logic [NUM_PLAYERS*NUM_ACTIONS*9-1:0] KEYMAP = KB_DEFAULT_KEYMAP,
    parameter int PAUSE_SKIP  = 7
) (
    input  logic                               clk,
    input  logic                               rst_n,
    kb_ctrl_decoder_if.slave                   kb,
    input  logic                               clear_all,
    output logic [NUM_PLAYERS*NUM_ACTIONS-1:0] keys,
    output logic                               seq_busy
`ifdef KB_PRESS_PULSE_EN
    ,
    output logic [NUM_PLAYERS*NUM_ACTIONS-1:0] press_pulse
`endif
);

    localparam int NK  = NUM_PLAYERS * NUM_ACTIONS;
    localparam int SKW = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);

    kb_state_t        state, state_nxt;
    logic [SKW-1:0]   skip_cnt, skip_nxt;
    logic             ev_make, ev_break;
    logic [8:0]       ev_key;
    logic [NK-1:0]    match;
    logic [NK-1:0]    keys_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
            seq_busy <= 1'b0;
            keys     <= '0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
            seq_busy <= (state_nxt != ST_IDLE);
            keys     <= keys_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        if (kb.code_valid) begin
            case (state)
                ST_IDLE: begin
                    if (kb.code == SC_E0) begin
                        state_nxt = ST_EXT;
                    end else if (kb.code == SC_F0) begin
                        state_nxt = ST_BRK;
                    end else if (kb.code == SC_E1) begin
                        state_nxt = ST_SKIP;
                        skip_nxt  = SKW'(PAUSE_SKIP);
                    end
                end
                ST_EXT: begin
                    if (kb.code == SC_F0) begin
                        state_nxt = ST_EXT_BRK;
                    end else if (kb.code != SC_E0 && kb.code != SC_E1) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: state_nxt = ST_IDLE;
                ST_SKIP: begin
                    // The pause sequence is a fixed-length blob; count it out.
                    if (skip_cnt <= SKW'(1)) begin
                        state_nxt = ST_IDLE;
                        skip_nxt  = '0;
                    end else begin
                        skip_nxt = skip_cnt - SKW'(1);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
        if (kb.frame_err || clear_all) begin
            state_nxt = ST_IDLE;
            skip_nxt  = '0;
        end
    end

    always_comb begin
        ev_make  = 1'b0;
        ev_break = 1'b0;
        ev_key   = {1'b0, kb.code};
        if (kb.code_valid && !kb.frame_err && !clear_all) begin
            case (state)
                ST_IDLE: begin
                    ev_make = (kb.code != SC_E0) && (kb.code != SC_F0) &&
                              (kb.code != SC_E1) && !kb_is_ignored(kb.code);
                end
                ST_EXT: begin
                    ev_make = (kb.code != SC_E0) && (kb.code != SC_F0) &&
                              (kb.code != SC_E1);
                    ev_key  = {1'b1, kb.code};
                end
                ST_BRK:     ev_break = 1'b1;
                ST_EXT_BRK: begin
                    ev_break = 1'b1;
                    ev_key   = {1'b1, kb.code};
                end
                default: ;
            endcase
        end
    end

    kb_keymap_match #(
        .NUM_KEYS (NK),
        .KEYMAP   (KEYMAP)
    ) u_match (
        .key   (ev_key),
        .match (match)
    );

    always_comb begin
        keys_nxt = keys;
        if (ev_make) begin
            keys_nxt = keys | match;
        end else if (ev_break) begin
            keys_nxt = keys & ~match;
        end
        if (clear_all) begin
            keys_nxt = '0;
        end
    end

`ifdef KB_PRESS_PULSE_EN
    // Rising edges only, so typematic repeats of a held key stay silent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            press_pulse <= '0;
        end else begin
            press_pulse <= keys_nxt & ~keys;
        end
    end
`endif

endmodule

// File: tb/tb_kb_ctrl_decoder.sv
// Scoreboard bench for kb_ctrl_decoder: directed byte vectors with hand-computed
// expected keys/seq_busy (and press_pulse when KB_PRESS_PULSE_EN is defined).
module tb_kb_ctrl_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear_all = 1'b0;
    logic [9:0] keys;
    logic       seq_busy;
`ifdef KB_PRESS_PULSE_EN
    logic [9:0] press_pulse;
`endif

    kb_ctrl_decoder_if kb ();

    kb_ctrl_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .kb        (kb),
        .clear_all (clear_all),
        .keys      (keys),
        .seq_busy  (seq_busy)
`ifdef KB_PRESS_PULSE_EN
        ,
        .press_pulse (press_pulse)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [9:0] k;
        logic       b;
        logic [9:0] p;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   req = 1'b0;
    bit   pending = 1'b0;

    always @(posedge clk) pending <= req;

    always @(negedge clk) begin
        if (pending) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: keys=%h busy=%b, no expected entry", keys, seq_busy);
            end else begin
                exp_t e;
                logic pulse_ok;
                e = q.pop_front();
`ifdef KB_PRESS_PULSE_EN
                pulse_ok = (press_pulse === e.p);
`else
                pulse_ok = 1'b1;
`endif
                vectors++;
                if (keys !== e.k || seq_busy !== e.b || !pulse_ok) begin
                    miscompares++;
`ifdef KB_PRESS_PULSE_EN
                    $display("FAIL %s: keys=%h busy=%b pulse=%h, expected keys=%h busy=%b pulse=%h",
                             e.nm, keys, seq_busy, press_pulse, e.k, e.b, e.p);
`else
                    $display("FAIL %s: keys=%h busy=%b, expected keys=%h busy=%b",
                             e.nm, keys, seq_busy, e.k, e.b);
`endif
                end
            end
        end
    end

    task automatic step(input string nm, input logic [7:0] c, input bit v, input bit fe,
                        input bit ca, input bit rn, input logic [9:0] ek, input logic eb,
                        input logic [9:0] ep);
        exp_t e;
        e.nm = nm; e.k = ek; e.b = eb; e.p = ep;
        q.push_back(e);
        kb.code       = c;
        kb.code_valid = v;
        kb.frame_err  = fe;
        clear_all     = ca;
        rst_n         = rn;
        req           = 1'b1;
        @(posedge clk);
        #1;
        kb.code_valid = 1'b0;
        kb.frame_err  = 1'b0;
        clear_all     = 1'b0;
        rst_n         = 1'b1;
        req           = 1'b0;
    endtask

    task automatic byte_in(input string nm, input logic [7:0] c, input logic [9:0] ek,
                           input logic eb, input logic [9:0] ep);
        step(nm, c, 1'b1, 1'b0, 1'b0, 1'b1, ek, eb, ep);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pause_bytes [6];
        logic [7:0] ign_bytes [7];
        pause_bytes = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0};
        ign_bytes   = '{8'hAA, 8'hFA, 8'hFF, 8'h00, 8'hEE, 8'hFC, 8'hFE};
        kb.code = 8'h00;
        kb.code_valid = 1'b0;
        kb.frame_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        step("reset0", 8'h1D, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000);
        step("reset1", 8'hE0, 1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000);

        byte_in("mk_1D",       8'h1D, 10'h001, 1'b0, 10'h001);
        byte_in("brk_pfx",     8'hF0, 10'h001, 1'b1, 10'h000);
        byte_in("brk_1D",      8'h1D, 10'h000, 1'b0, 10'h000);

        byte_in("ext_pfx",     8'hE0, 10'h000, 1'b1, 10'h000);
        byte_in("mk_e75",      8'h75, 10'h020, 1'b0, 10'h020);
        byte_in("kp8_75",      8'h75, 10'h020, 1'b0, 10'h000);
        byte_in("ext_pfx2",    8'hE0, 10'h020, 1'b1, 10'h000);
        byte_in("ext_brk_pfx", 8'hF0, 10'h020, 1'b1, 10'h000);
        byte_in("brk_e75",     8'h75, 10'h000, 1'b0, 10'h000);

        byte_in("pause_e1",    8'hE1, 10'h000, 1'b1, 10'h000);
        foreach (pause_bytes[i]) byte_in("pause_skip", pause_bytes[i], 10'h000, 1'b1, 10'h000);
        byte_in("pause_last",  8'h77, 10'h000, 1'b0, 10'h000);
        byte_in("mk_post_pause", 8'h1D, 10'h001, 1'b0, 10'h001);
        byte_in("brk_pfx2",    8'hF0, 10'h001, 1'b1, 10'h000);
        byte_in("brk_1D_2",    8'h1D, 10'h000, 1'b0, 10'h000);

        byte_in("mk_3B",       8'h3B, 10'h010, 1'b0, 10'h010);
        byte_in("mk_4C",       8'h4C, 10'h210, 1'b0, 10'h200);
        repeat (4) byte_in("typematic_4C", 8'h4C, 10'h210, 1'b0, 10'h000);

        byte_in("ext_pfx3",    8'hE0, 10'h210, 1'b1, 10'h000);
        step("ferr_discard",   8'h75, 1'b1, 1'b1, 1'b0, 1'b1, 10'h210, 1'b0, 10'h000);
        byte_in("mk_23",       8'h23, 10'h218, 1'b0, 10'h008);
        byte_in("ext_pfx4",    8'hE0, 10'h218, 1'b1, 10'h000);
        step("ferr_only",      8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 10'h218, 1'b0, 10'h000);
        byte_in("plain_74",    8'h74, 10'h218, 1'b0, 10'h000);

        step("clear_vs_byte",  8'h1D, 1'b1, 1'b0, 1'b1, 1'b1, 10'h000, 1'b0, 10'h000);
        byte_in("ext_pfx5",    8'hE0, 10'h000, 1'b1, 10'h000);
        step("clear_vs_ferr",  8'h75, 1'b1, 1'b1, 1'b1, 1'b1, 10'h000, 1'b0, 10'h000);
        byte_in("after_clear", 8'h75, 10'h000, 1'b0, 10'h000);

        foreach (ign_bytes[i]) byte_in("ignored", ign_bytes[i], 10'h000, 1'b0, 10'h000);

        byte_in("mk_1C",       8'h1C, 10'h004, 1'b0, 10'h004);
        byte_in("brk_pfx3",    8'hF0, 10'h004, 1'b1, 10'h000);
        step("rst_mid_seq",    8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000);
        byte_in("mk_1C_post",  8'h1C, 10'h004, 1'b0, 10'h004);

        byte_in("pause_e1_2",  8'hE1, 10'h004, 1'b1, 10'h000);
        byte_in("pause_b1",    8'h14, 10'h004, 1'b1, 10'h000);
        step("ferr_in_skip",   8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 10'h004, 1'b0, 10'h000);
        byte_in("mk_1B",       8'h1B, 10'h006, 1'b0, 10'h002);

        byte_in("ext_pfx6",    8'hE0, 10'h006, 1'b1, 10'h000);
        byte_in("ext_AA",      8'hAA, 10'h006, 1'b0, 10'h000);
        byte_in("ext_pfx7",    8'hE0, 10'h006, 1'b1, 10'h000);
        byte_in("ext_brk_pfx2", 8'hF0, 10'h006, 1'b1, 10'h000);
        byte_in("brk_released", 8'h72, 10'h006, 1'b0, 10'h000);
        byte_in("ext_pfx8",    8'hE0, 10'h006, 1'b1, 10'h000);
        byte_in("ext_e0_again", 8'hE0, 10'h006, 1'b1, 10'h000);
        byte_in("mk_e6B",      8'h6B, 10'h086, 1'b0, 10'h080);

        repeat (3) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/kb_ctrl_decoder.md
KB_CTRL_DECODER -- requirements
Module: kb_ctrl_decoder

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of players (1..4).
REQ-002 Parameter NUM_ACTIONS, default 5, actions per player; index 0..4 = up, down, left, right, shoot.
REQ-003 Parameter KEYMAP, NUM_PLAYERS*NUM_ACTIONS*9 bits, default P0 = {0,1D},{0,1B},{0,1C},{0,23},{0,3B}, P1 = {1,75},{1,72},{1,6B},{1,74},{0,4C}; entry i = bits [9i+8:9i], bit 8 = E0-extended flag, bits 7:0 = scancode; i = player*NUM_ACTIONS+action.
REQ-004 Parameter PAUSE_SKIP, default 7, bytes discarded after an E1 prefix.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 code  in  8  received PS/2 scancode byte.
REQ-008 code_valid  in  1  one-cycle strobe qualifying code.
REQ-009 frame_err  in  1  one-cycle strobe: receiver parity/framing error.
REQ-010 clear_all  in  1  release every key (focus loss, round restart).
REQ-011 keys  out  NUM_PLAYERS*NUM_ACTIONS  held state per action, bit i = KEYMAP entry i.
REQ-012 seq_busy  out  1  high while FSM is not in IDLE.

Function
REQ-013 FSM states IDLE, EXT, BRK, EXT_BRK, SKIP; only code_valid cycles advance it.
REQ-014 IDLE: E0->EXT, F0->BRK, E1->SKIP with skip counter loaded PAUSE_SKIP, any other byte = make code {0,code}, stay IDLE.
REQ-015 EXT: F0->EXT_BRK; E0/E1 ignored, stay EXT; other byte = make {1,code}, ->IDLE.
REQ-016 BRK: byte = break {0,code}, ->IDLE; EXT_BRK: byte = break {1,code}, ->IDLE.
REQ-017 SKIP: each byte decrements counter, no key effect; counter reaching 0 ->IDLE.
REQ-018 Bytes 00, AA, EE, FA, FC, FE, FF in IDLE are ignored, no key effect.
REQ-019 Make sets, break clears, every keys bit whose entry matches all 9 bits; duplicate entries all update; unmatched codes ignored.
REQ-020 keys registered; update visible the cycle after the code_valid edge carrying the final byte (latency 1).
REQ-021 Repeated make of a held key (typematic) leaves the bit set; break of a released key leaves it clear.
REQ-022 frame_err: FSM ->IDLE, skip counter cleared, keys unchanged; a simultaneous code_valid byte is discarded.
REQ-023 clear_all: keys all 0 and FSM ->IDLE next cycle; wins over simultaneous code_valid and frame_err.
REQ-024 seq_busy = (state != IDLE), registered with state.

Reset
REQ-025 rst_n low at a clock edge: keys = 0, state = IDLE, skip counter = 0, seq_busy = 0, press_pulse = 0; reset wins over all inputs.
REQ-026 Reset mid-sequence (e.g. after E0) discards the prefix; the next byte decodes from IDLE.

Configuration
REQ-027 Macro KB_PRESS_PULSE_EN defined: extra output press_pulse, width equal to keys, a bit high for exactly one cycle when its keys bit goes 0->1; typematic repeats produce no pulse.
REQ-028 Macro undefined: no press_pulse port and no related logic; all else identical.

Structure
REQ-029 Shared package kb_pkg holds scancode constants (E0, E1, F0, ignored codes), FSM state typedef, action index constants and default keymap constant.
REQ-030 One sub-module kb_keymap_match: combinational 9-bit key vs KEYMAP comparator returning match vector; FSM and key registers stay in kb_ctrl_decoder.

Verification
REQ-031 Byte 1D -> keys[0]=1 next cycle; bytes F0,1D -> keys[0]=0; seq_busy=1 only between F0 and 1D.
REQ-032 Bytes E0,75 -> keys[5]=1; plain 75 (keypad 8) -> keys unchanged; E0,F0,75 -> keys[5]=0.
REQ-033 Bytes E1,14,77,E1,F0,14,F0,77 -> keys unchanged, seq_busy high 7 byte-cycles, then 1D sets keys[0].
REQ-034 Set keys[4], keys[9]; byte 4C repeated 5 times -> keys[9] stays 1; with KB_PRESS_PULSE_EN press_pulse[9] pulses once, on first only.
REQ-035 Bytes E0 then frame_err, then 23 -> keys[3]=1, keys[8] unaffected; clear_all with code_valid=1,code=1D same cycle -> keys=0.
REQ-036 rst_n low after F0; release, then byte 1C -> keys[2]=1 (make, not break).
